// File: rtl/id_stage_pkg.sv
// Shared pipeline package: datapath widths, instruction field positions
// and small decode helpers used by the decode stage and its register file.
package id_stage_pkg;

  // Default datapath and register-address widths
  localparam int ID_DATA_W = 32;
  localparam int ID_REG_AW = 5;

  // Register 0 is hard-wired to zero
  localparam int REG_ZERO  = 0;

  // Instruction word layout (MIPS-style R/I formats)
  localparam int INSTR_W   = 32;
  localparam int FIELD_W   = 5;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int IMM_W     = IMM_MSB - IMM_LSB + 1;

  // Register-address fields and immediate pulled out of one instruction
  typedef struct packed {
    logic [FIELD_W-1:0] rs;
    logic [FIELD_W-1:0] rt;
    logic [FIELD_W-1:0] rd;
    logic [IMM_W-1:0]   imm;
  } id_fields_t;

  // Slice the instruction word into its decode fields
  function automatic id_fields_t decode_fields(input logic [INSTR_W-1:0] instr);
    id_fields_t f;
    f.rs  = instr[RS_MSB:RS_LSB];
    f.rt  = instr[RT_MSB:RT_LSB];
    f.rd  = instr[RD_MSB:RD_LSB];
    f.imm = instr[IMM_MSB:IMM_LSB];
    return f;
  endfunction

  // Replicate the immediate's sign bit up to a full instruction word
  function automatic logic [INSTR_W-1:0] sign_extend(input logic [IMM_W-1:0] imm);
    return {{(INSTR_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: instruction in, write-back and EX hazard info in,
// operands, immediate, register fields and stall out.
interface id_stage_if
  import id_stage_pkg::*;
#(
  parameter int DATA_W = ID_DATA_W,
  parameter int REG_AW = ID_REG_AW
);

  // From IF/ID
  logic [INSTR_W-1:0] instruction_ID;

  // From write-back
  logic               RegWrite_WB;
  logic [REG_AW-1:0]  Write_Reg_WB;
  logic [DATA_W-1:0]  Write_Data_WB;

  // From EX (load-use detection)
  logic               MemRead_EX;
  logic [REG_AW-1:0]  Rt_EX;

  // To ID/EX and hazard control
  logic [DATA_W-1:0]  Read_Data_1_ID;
  logic [DATA_W-1:0]  Read_Data_2_ID;
  logic [INSTR_W-1:0] signExtended_ID;
  logic [REG_AW-1:0]  Rs_ID;
  logic [REG_AW-1:0]  Rt_ID;
  logic [REG_AW-1:0]  Rd_ID;
  logic               stall_ID;

  // Pipeline side: drives the instruction and write-back, consumes results
  modport master (
    output instruction_ID, RegWrite_WB, Write_Reg_WB, Write_Data_WB,
           MemRead_EX, Rt_EX,
    input  Read_Data_1_ID, Read_Data_2_ID, signExtended_ID,
           Rs_ID, Rt_ID, Rd_ID, stall_ID
  );

  // Decode stage side
  modport slave (
    input  instruction_ID, RegWrite_WB, Write_Reg_WB, Write_Data_WB,
           MemRead_EX, Rt_EX,
    output Read_Data_1_ID, Read_Data_2_ID, signExtended_ID,
           Rs_ID, Rt_ID, Rd_ID, stall_ID
  );

endinterface

// File: rtl/id_stage_reg_file.sv
// Register file: one write port, two combinational read ports with
// write-before-read bypass. Register 0 is never written and reads zero.
module reg_file
  import id_stage_pkg::*;
#(
  parameter int DATA_W = ID_DATA_W,
  parameter int REG_AW = ID_REG_AW
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

  logic [DATA_W-1:0] r_regs [NREG];

  // A write to register 0 is dropped entirely, both for storage and bypass
  logic w_wr_en;
  assign w_wr_en = i_we && (i_waddr != ZERO_ADDR);

  // Storage: asynchronous clear of every entry, otherwise one write per edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports share identical logic; index 0 is rs, index 1 is rt
  logic [REG_AW-1:0] w_raddr [2];
  logic [DATA_W-1:0] w_rdata [2];

  assign w_raddr[0] = i_raddr1;
  assign w_raddr[1] = i_raddr2;

  // Bypass lets the consumer see this cycle's write-back before the edge,
  // so both ports forward independently when they hit the same register
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      logic w_hit_zero;
      logic w_hit_bypass;

      assign w_hit_zero   = (w_raddr[gi] == ZERO_ADDR);
      assign w_hit_bypass = w_wr_en && (i_waddr == w_raddr[gi]);

      assign w_rdata[gi] = w_hit_zero   ? '0      :
                           w_hit_bypass ? i_wdata :
                                          r_regs[w_raddr[gi]];
    end
  endgenerate

  assign o_rdata1 = w_rdata[0];
  assign o_rdata2 = w_rdata[1];

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: register-file read with write-back bypass,
// immediate sign extension and load-use stall detection.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W = ID_DATA_W,
  parameter int REG_AW = ID_REG_AW
)(
  input  logic        clk,
  input  logic        rst_n,
  id_stage_if.slave   bus
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

  // Decode fields once; everything downstream uses these
  id_fields_t        w_fields;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;

  assign w_fields = decode_fields(bus.instruction_ID);
  assign w_rs     = REG_AW'(w_fields.rs);
  assign w_rt     = REG_AW'(w_fields.rt);
  assign w_rd     = REG_AW'(w_fields.rd);

  // Opcode/funct bits are decoded by the control unit, not here
  logic w_unused_opcode;
  assign w_unused_opcode = ^bus.instruction_ID[INSTR_W-1:RS_MSB+1];

  // Register file with bypassed read ports
  reg_file #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (bus.RegWrite_WB),
    .i_waddr  (bus.Write_Reg_WB),
    .i_wdata  (bus.Write_Data_WB),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (bus.Read_Data_1_ID),
    .o_rdata2 (bus.Read_Data_2_ID)
  );

  // Immediate and register fields forwarded to ID/EX
  assign bus.signExtended_ID = sign_extend(w_fields.imm);
  assign bus.Rs_ID           = w_rs;
  assign bus.Rt_ID           = w_rt;
  assign bus.Rd_ID           = w_rd;

  // Load-use hazard: the load in EX targets a register this instruction
  // reads. A load into r0 produces nothing to wait for.
  logic w_ex_load_live;
  logic w_src_match;

  assign w_ex_load_live = bus.MemRead_EX && (bus.Rt_EX != ZERO_ADDR);
  assign w_src_match    = (bus.Rt_EX == w_rs) || (bus.Rt_EX == w_rt);
  assign bus.stall_ID   = w_ex_load_live && w_src_match;

endmodule
